// File: rtl/bcd_serial_driver.sv
// bcd_serial_driver: latches a binary value, converts it to BCD with
// double-dabble, then shifts the digits out serially (MSB digit, MSB bit
// first) on sclk/sdo framed by data_enable, ending with a one-cycle dclk.
// Frames start on a start pulse or on a pending auto-refresh.
// Optional build macro: BCD_SERIAL_DRIVER_BLANK_EN -- leading zero digits
// (all but the least significant) are sent as the blank code 4'hA.
module bcd_serial_driver #(
  parameter int unsigned IN_WIDTH      = 14,
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned CLK_DIV       = 256,
  parameter int unsigned REFRESH_TICKS = 131072
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] num,
  input  logic                error,
  input  logic                start,
  output logic                sclk,
  output logic                data_enable,
  output logic                sdo,
  output logic                dclk,
  output logic                busy
);

  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned CNT_MAX = (IN_WIDTH > BCD_W) ? IN_WIDTH : BCD_W;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned REF_W   = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;

  // Largest value representable in DIGITS decimal digits (10^DIGITS - 1).
  function automatic logic [63:0] max_value(input int unsigned digits);
    logic [63:0] v;
    v = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_value(DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    SHIFT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IN_WIDTH-1:0] bin_q, bin_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               sclk_q, sclk_d;
  logic               sdo_q, sdo_d;
  logic               de_q, de_d;
  logic               pending_q, pending_d;
  logic [REF_W-1:0]   ref_q, ref_d;

  logic               wrap;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   step;
  logic [BCD_W-1:0]   frame;
`ifdef BCD_SERIAL_DRIVER_BLANK_EN
  logic               lead;
`endif

  // Free-running refresh counter; wrap marks the end of each period.
  always_comb begin
    ref_d = ref_q;
    wrap  = 1'b0;
    if (REFRESH_TICKS != 0) begin
      if (ref_q == REF_W'(REFRESH_TICKS - 1)) begin
        ref_d = '0;
        wrap  = 1'b1;
      end else begin
        ref_d = ref_q + 1'b1;
      end
    end
  end

  // One double-dabble step: add 3 to digits >= 5, then shift in the next bit.
  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    step = {adj[BCD_W-2:0], bin_q[IN_WIDTH-1]};
  end

  // Final digit pattern: error and overflow override the conversion result.
  always_comb begin
    frame = step;
`ifdef BCD_SERIAL_DRIVER_BLANK_EN
    lead = 1'b1;
`endif
    if (err_q) begin
      frame = '1;
    end else if (ovf_q) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        frame[4*i +: 4] = 4'hE;
      end
    end else begin
`ifdef BCD_SERIAL_DRIVER_BLANK_EN
      // Walk down from the top digit; stop blanking at the first non-zero.
      for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
        if (lead && (step[4*i +: 4] == 4'd0)) begin
          frame[4*i +: 4] = 4'hA;
        end else begin
          lead = 1'b0;
        end
      end
`endif
    end
  end

  // Next-state and datapath control for the IDLE/CONVERT/SHIFT/DONE sequence.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    sclk_d    = sclk_q;
    sdo_d     = sdo_q;
    de_d      = de_q;
    pending_d = pending_q | wrap;

    case (state_q)
      IDLE: begin
        if (start || pending_q) begin
          state_d   = CONVERT;
          bin_d     = num;
          err_d     = error;
          ovf_d     = (64'(num) > MAX_VAL);
          bcd_d     = '0;
          cnt_d     = '0;
          pending_d = 1'b0;
        end
      end

      CONVERT: begin
        bin_d = bin_q << 1;
        bcd_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(IN_WIDTH - 1)) begin
          // Load the final pattern and present its first bit on SHIFT entry.
          state_d = SHIFT;
          bcd_d   = frame;
          sdo_d   = frame[BCD_W-1];
          de_d    = 1'b1;
          sclk_d  = 1'b0;
          div_d   = '0;
          cnt_d   = '0;
        end
      end

      SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (cnt_q == CNT_W'(BCD_W - 1)) begin
            state_d = DONE;
            sclk_d  = 1'b0;
            sdo_d   = 1'b0;
            de_d    = 1'b0;
            cnt_d   = '0;
          end else begin
            // Falling sclk: advance to the next bit.
            sclk_d = 1'b0;
            cnt_d  = cnt_q + 1'b1;
            bcd_d  = bcd_q << 1;
            sdo_d  = bcd_q[BCD_W-2];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      div_q     <= '0;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
      de_q      <= 1'b0;
      pending_q <= 1'b0;
      ref_q     <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
      de_q      <= de_d;
      pending_q <= pending_d;
      ref_q     <= ref_d;
    end
  end

  assign sclk        = sclk_q;
  assign sdo         = sdo_q;
  assign data_enable = de_q;
  assign dclk        = (state_q == DONE);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_serial_driver.sv
// Testbench for bcd_serial_driver: instance A (14-bit, 4 digits, CLK_DIV=2,
// REFRESH_TICKS=50) is checked every cycle against a frame-level model;
// instance B (20-bit, 6 digits, CLK_DIV=1, no refresh) gets directed frames.
module tb_bcd_serial_driver;

  localparam int W_A = 14;
  localparam int D_A = 4;
  localparam int K_A = 2;
  localparam int R_A = 50;
  localparam int SHIFT_A = 8 * D_A * K_A;
  localparam int FRAME_A = W_A + SHIFT_A + 1;      // offset of the DONE cycle
  localparam int DCLK_B  = 1 + 20 + 8 * 6 * 1;

`ifdef BCD_SERIAL_DRIVER_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        error = 1'b0;
  logic [13:0] num = '0;
  logic        sclk, data_enable, sdo, dclk, busy;

  logic        rst_b = 1'b1;
  logic        start_b = 1'b0;
  logic        error_b = 1'b0;
  logic [19:0] num_b = '0;
  logic        sclk_b, de_b, sdo_b, dclk_b, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_serial_driver #(
    .IN_WIDTH(W_A), .DIGITS(D_A), .CLK_DIV(K_A), .REFRESH_TICKS(R_A)
  ) dut_a (
    .clk(clk), .rst(rst), .num(num), .error(error), .start(start),
    .sclk(sclk), .data_enable(data_enable), .sdo(sdo), .dclk(dclk), .busy(busy)
  );

  bcd_serial_driver #(
    .IN_WIDTH(20), .DIGITS(6), .CLK_DIV(1), .REFRESH_TICKS(0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .num(num_b), .error(error_b), .start(start_b),
    .sclk(sclk_b), .data_enable(de_b), .sdo(sdo_b), .dclk(dclk_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected digit pattern from decimal arithmetic (low 4*d bits used).
  function automatic logic [23:0] build_frame(input longint unsigned n, input logic e, input int d);
    logic [23:0]     f;
    logic [3:0]      dg [6];
    longint unsigned v, lim;
    bit              lead;
    f   = '0;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    v = n;
    for (int i = 0; i < 6; i++) begin
      dg[i] = 4'(v % 10);
      v     = v / 10;
    end
    lead = 1'b1;
    if (BLANK) begin
      for (int i = d - 1; i >= 1; i--) begin
        if (lead && dg[i] == 4'd0) dg[i] = 4'hA;
        else lead = 1'b0;
      end
    end
    for (int i = 0; i < d; i++) begin
      f[4*i +: 4] = e ? 4'hF : ((n >= lim) ? 4'hE : dg[i]);
    end
    return f;
  endfunction

  // Frame-level model of instance A, advanced once per clock, checked every cycle.
  bit          m_busy = 1'b0;
  bit          m_pend = 1'b0;
  int          m_ref  = 0;
  int          m_k    = 0;
  logic [23:0] m_frame = '0;

  initial begin : model_check
    bit         wrap;
    int         s;
    logic [4:0] exp_o;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 1'b0;
        m_pend = 1'b0;
        m_ref  = 0;
        m_k    = 0;
      end else begin
        wrap  = (m_ref == R_A - 1);
        m_ref = wrap ? 0 : m_ref + 1;
        if (!m_busy) begin
          if (start || m_pend) begin
            m_busy  = 1'b1;
            m_k     = 1;
            m_frame = build_frame(longint'(num), error, D_A);
            m_pend  = 1'b0;
          end else begin
            m_pend = m_pend | wrap;
          end
        end else begin
          m_pend = m_pend | wrap;
          m_k++;
          if (m_k > FRAME_A) begin
            m_busy = 1'b0;
            m_k    = 0;
          end
        end
      end
      // {sclk, sdo, data_enable, dclk, busy}
      exp_o = 5'b0;
      if (m_busy) begin
        exp_o[0] = 1'b1;
        if (m_k > W_A && m_k <= W_A + SHIFT_A) begin
          s        = m_k - W_A - 1;
          exp_o[4] = ((s % (2 * K_A)) >= K_A);
          exp_o[3] = m_frame[4 * D_A - 1 - s / (2 * K_A)];
          exp_o[2] = 1'b1;
        end else if (m_k == FRAME_A) begin
          exp_o[1] = 1'b1;
        end
      end
      check("cycle_outputs", 64'({sclk, sdo, data_enable, dclk, busy}), 64'(exp_o));
    end
  end

  // Reset the chosen instance, start one frame, capture bits at sclk rises.
  task automatic run_frame(input bit use_b, input longint unsigned n, input logic e,
                           output logic [23:0] bits, output int nb, output int dc);
    logic prev, s_sclk, s_sdo, s_dclk;
    int   cyc;
    @(negedge clk); #1;
    if (use_b) begin rst_b = 1'b1; start_b = 1'b0; end
    else begin rst = 1'b1; start = 1'b0; end
    repeat (2) @(negedge clk);
    #1;
    if (use_b) begin rst_b = 1'b0; start_b = 1'b1; num_b = 20'(n); error_b = e; end
    else begin rst = 1'b0; start = 1'b1; num = 14'(n); error = e; end
    bits = '0; nb = 0; dc = -1; cyc = 0; prev = 1'b0;
    while (dc < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      s_sclk = use_b ? sclk_b : sclk;
      s_sdo  = use_b ? sdo_b  : sdo;
      s_dclk = use_b ? dclk_b : dclk;
      if (s_sclk && !prev) begin
        bits = {bits[22:0], s_sdo};
        nb++;
      end
      prev = s_sclk;
      if (s_dclk) dc = cyc;
      #1;
      if (use_b) start_b = 1'b0;
      else start = 1'b0;
    end
  endtask

  longint unsigned dn [6] = '{6942, 10000, 5, 42, 9999, 0};
  logic            dE [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [15:0]     dx [6] = '{16'h6942, 16'hEEEE, 16'hFFFF,
                              (BLANK ? 16'hAA42 : 16'h0042), 16'h9999,
                              (BLANK ? 16'hAAA0 : 16'h0000)};

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    logic [23:0] bits;
    int          nb, dc, rst_hold;

    // Pin the reference pattern builder with hand-computed values.
    check("model_6942",  64'(build_frame(6942, 1'b0, 4)), 64'h6942);
    check("model_10000", 64'(build_frame(10000, 1'b0, 4)), 64'hEEEE);
    check("model_err5",  64'(build_frame(5, 1'b1, 4)), 64'hFFFF);
    check("model_42",    64'(build_frame(42, 1'b0, 4)), BLANK ? 64'hAA42 : 64'h0042);

    @(negedge clk);
    check("reset_state", 64'({sclk, sdo, data_enable, dclk, busy}), 64'h0);

    // Directed frames on instance A: bit pattern, bit count and dclk latency.
    for (int i = 0; i < 6; i++) begin
      run_frame(1'b0, dn[i], dE[i], bits, nb, dc);
      check($sformatf("a_bits_%0d", dn[i]), 64'(bits[15:0]), 64'(dx[i]));
      check($sformatf("a_nbits_%0d", dn[i]), 64'(nb), 64'd16);
      check($sformatf("a_dclk_cycle_%0d", dn[i]), 64'(dc), 64'd79);
    end

    // Reset in the middle of bit 7, then a clean frame afterwards.
    @(negedge clk); #1;
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0; start = 1'b1; num = 14'd1234; error = 1'b0;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (43) @(negedge clk);
    check("mid_frame_de", 64'(data_enable), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("reset_mid_frame", 64'({sclk, sdo, data_enable, dclk, busy}), 64'h0);
    run_frame(1'b0, 1234, 1'b0, bits, nb, dc);
    check("after_reset_bits", 64'(bits[15:0]), 64'h1234);
    check("after_reset_dclk", 64'(dc), 64'd79);

    // Instance B: 6-digit conversion, including the overflow boundary.
    run_frame(1'b1, 999999, 1'b0, bits, nb, dc);
    check("b_bits_999999", 64'(bits), 64'h999999);
    check("b_nbits", 64'(nb), 64'd24);
    check("b_dclk_cycle", 64'(dc), 64'(DCLK_B));
    @(negedge clk);
    check("b_idle_after", 64'({sclk_b, sdo_b, de_b, dclk_b, busy_b}), 64'h0);
    run_frame(1'b1, 1000000, 1'b0, bits, nb, dc);
    check("b_bits_1000000", 64'(bits), 64'hEEEEEE);
    run_frame(1'b1, 1000, 1'b0, bits, nb, dc);
    check("b_bits_1000", 64'(bits), BLANK ? 64'hAA1000 : 64'h001000);

    // Randomized traffic on instance A; the model process checks every cycle.
    rst_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      if (rst_hold > 0) begin
        rst_hold--;
        rst = (rst_hold > 0);
      end else if ($urandom_range(0, 299) == 0) begin
        rst      = 1'b1;
        rst_hold = int'($urandom_range(1, 3));
      end
      start = ($urandom_range(0, 5) == 0);
      error = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 7))
        0:       num = 14'd0;
        1:       num = 14'd9999;
        2:       num = 14'd10000;
        3:       num = '1;
        4:       num = 14'($urandom_range(0, 99));
        default: num = 14'($urandom_range(0, 16383));
      endcase
    end
    @(negedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
